// File: rtl/bitdump_capture.sv
// rtl/bitdump_capture.sv - one-shot sig/sig1 snapshot packer with byte readout buffer; BITDUMP_TRIG_EN adds sig rising-edge trigger
// The head-byte output is named head_byte because "byte" is a reserved word.
module bitdump_capture #(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig,
    input  logic          sig1,
    input  logic          arm,
    input  logic          mode,
    input  logic [7:0]    div,
    input  logic          pause,
    input  logic          next,
    output logic [7:0]    head_byte,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          underflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [7:0]    mem [DEPTH];
    logic          mode_r;
    logic [7:0]    div_r;
    logic [7:0]    div_cnt;
    logic [6:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic          next_q, pop_req;
    logic          sampling, tick, byte_full, we, pop, trigger;
    logic [7:0]    packed_byte;
    logic [CW-1:0] count_nxt;

`ifdef BITDUMP_TRIG_EN
    logic sig_q;
    always_ff @(posedge clk) begin
        if (!rst) sig_q <= 1'b0;
        else      sig_q <= sig;
    end
    assign trigger = sig & ~sig_q;
`else
    assign trigger = 1'b1;
`endif

    always_comb begin
        sampling    = (state == CAPTURE) && !pause;
        tick        = sampling && (div_cnt == div_r);
        byte_full   = mode_r ? (bit_cnt == 3'd6) : (bit_cnt == 3'd7);
        packed_byte = mode_r ? {shreg[5:0], sig, sig1} : {shreg[6:0], sig};
        we          = tick && byte_full;
        pop         = pop_req && (count != '0);
        rd_ptr_nxt  = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt   = count;
        if (we && !pop)      count_nxt = count + CW'(1);
        else if (!we && pop) count_nxt = count - CW'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            ARMED:   if (trigger) state_nxt = CAPTURE;
            CAPTURE: if (we && count_nxt == CW'(DEPTH)) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (arm) state_nxt = ARMED;
    end

    always_ff @(posedge clk) begin
        if (rst && !arm && we) mem[wr_ptr] <= packed_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            div_r     <= '0;
            div_cnt   <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_q    <= 1'b0;
            pop_req   <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
            head_byte <= '0;
        end else begin
            state  <= state_nxt;
            next_q <= next;
            if (arm) begin
                mode_r    <= mode;
                div_r     <= div;
                div_cnt   <= '0;
                shreg     <= '0;
                bit_cnt   <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                pop_req   <= 1'b0;
                done      <= 1'b0;
                underflow <= 1'b0;
                head_byte <= '0;
            end else begin
                pop_req <= next & ~next_q;
                count   <= count_nxt;
                rd_ptr  <= rd_ptr_nxt;
                if (we) wr_ptr <= wr_ptr + AW'(1);
                if (sampling) div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                if (tick) begin
                    if (byte_full) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (mode_r) begin
                        shreg   <= {shreg[4:0], sig, sig1};
                        bit_cnt <= bit_cnt + 3'd2;
                    end else begin
                        shreg   <= {shreg[5:0], sig};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                if (state == CAPTURE && we && count_nxt == CW'(DEPTH)) done <= 1'b1;
                if (pop_req && count == '0) underflow <= 1'b1;
                // A byte written into the slot that becomes the head bypasses the RAM read.
                if (count_nxt == '0)                  head_byte <= '0;
                else if (we && wr_ptr == rd_ptr_nxt)  head_byte <= packed_byte;
                else                                  head_byte <= mem[rd_ptr_nxt];
            end
        end
    end
endmodule

// File: tb/tb_bitdump_capture.sv
// tb/tb_bitdump_capture.sv - scoreboard bench for bitdump_capture
module tb_bitdump_capture;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, sig, sig1, arm, mode, pause, next;
    logic [7:0]    div;
    logic [7:0]    head_byte;
    logic [CW-1:0] count;
    logic          done, underflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       mon_next_q = 1'b0;

    bitdump_capture #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sig(sig), .sig1(sig1), .arm(arm), .mode(mode),
        .div(div), .pause(pause), .next(next), .head_byte(head_byte),
        .count(count), .done(done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a rising next with data held means the current head is consumed.
    always @(negedge clk) begin
        if (rst && !arm && next && !mon_next_q && count != '0) begin
            if (exp_q.size() == 0) check("sb_unexpected_pop", 32'(head_byte), 32'hFFFF_FFFF);
            else check("sb_byte", 32'(head_byte), 32'(exp_q.pop_front()));
        end
        mon_next_q = next;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        next = 1'b1; step();
        next = 1'b0; step(); step();
    endtask

    task automatic start(input logic m, input logic [7:0] d);
        mode = m; div = d; arm = 1'b1; step();
        arm = 1'b0; step();
    endtask

    task automatic wait_done(input int max, input string nm);
        int n = 0;
        while (!done && n < max) begin step(); n++; end
        check(nm, 32'(done), 32'd1);
    endtask

    logic [7:0] pat   = 8'hA3;
    logic [7:0] strm [17] = '{8'h5C, 8'h3A, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'hC3, 8'h3C,
                              8'h81, 8'h7E, 8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    function automatic logic sbit(input int k);
        logic [7:0] b;
        if (k >= 136) return 1'b0;
        b = strm[k / 8];
        return b[7 - (k % 8)];
    endfunction

    initial begin
        rst = 1'b0; sig = 1'b0; sig1 = 1'b0; arm = 1'b0; mode = 1'b0;
        pause = 1'b0; next = 1'b0; div = 8'd0;
        repeat (3) step();
        check("rst_byte", 32'(head_byte), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        rst = 1'b1; step();

`ifndef BITDUMP_TRIG_EN
        // Mode 0, div 0, repeating A3 pattern
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hA3);
        start(1'b0, 8'd0);
        for (int k = 0; k < 8 * DEPTH; k++) begin
            sig = pat[7 - (k % 8)];
            if (k == 8 * DEPTH - 1) check("m0_done_early", 32'(done), 32'd0);
            step();
        end
        check("m0_done", 32'(done), 32'd1);
        check("m0_full", 32'(count), 32'(DEPTH));
        next = 1'b1; step();
        check("rd_lat_n1", 32'(count), 32'(DEPTH));
        next = 1'b0; step();
        check("rd_lat_n2", 32'(count), 32'(DEPTH - 1));
        step();
        for (int i = 1; i < DEPTH; i++) pop_one();
        check("m0_empty", 32'(count), 32'd0);
        check("m0_idle", 32'(dut.state), 32'd0);

        // Underflow after empty
        pop_one(); pop_one();
        check("uf_byte", 32'(head_byte), 32'h0);
        check("uf_count", 32'(count), 32'd0);
        check("uf_flag", 32'(underflow), 32'd1);

        // Mode 1, div 3, sig=1 sig1=0 -> AA
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hAA);
        sig = 1'b1; sig1 = 1'b0; mode = 1'b1; div = 8'd3; arm = 1'b1; step();
        check("arm_clr_uf", 32'(underflow), 32'd0);
        arm = 1'b0; step();
        repeat (15) step();
        check("m1_before_first", 32'(count), 32'd0);
        step();
        check("m1_first", 32'(count), 32'd1);
        wait_done(400, "m1_done");
        check("m1_full", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop_one();
        check("m1_empty", 32'(count), 32'd0);

        // Pause window with a held next
        for (int i = 0; i < 17; i++) exp_q.push_back(strm[i]);
        start(1'b0, 8'd0);
        begin
            int k = 0, pc = 0, n = 0;
            while (!done && n < 600) begin
                if (k == 20 && pc < 100) begin
                    pause = 1'b1;
                    sig   = ~sbit(k);
                    next  = (pc >= 10 && pc < 15);
                    if (pc == 0)  check("pause_cnt_start", 32'(count), 32'd2);
                    if (pc == 9)  check("pause_cnt_frozen", 32'(count), 32'd2);
                    if (pc == 99) check("pause_held_next", 32'(count), 32'd1);
                    pc++;
                end else begin
                    pause = 1'b0; next = 1'b0;
                    sig = sbit(k);
                    k++;
                end
                step(); n++;
            end
            check("pause_done", 32'(done), 32'd1);
        end
        check("pause_full", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop_one();
        check("pause_empty", 32'(count), 32'd0);
`endif

        // Mid-capture reset
        sig = 1'b1;
        start(1'b0, 8'd0);
        repeat (30) step();
        rst = 1'b0; step();
        check("mrst_count1", 32'(count), 32'd0);
        step(); step();
        check("mrst_byte", 32'(head_byte), 32'h0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_underflow", 32'(underflow), 32'd0);
        check("mrst_state", 32'(dut.state), 32'd0);
        rst = 1'b1; step();

`ifdef BITDUMP_TRIG_EN
        sig = 1'b0;
        start(1'b0, 8'd0);
        repeat (50) step();
        check("trig_no_write", 32'(count), 32'd0);
        check("trig_armed", 32'(dut.state), 32'd1);
        exp_q.push_back(8'hFF);
        sig = 1'b1;
        repeat (12) step();
        check("trig_first", 32'(count), 32'd1);
        check("trig_msb", 32'(head_byte[7]), 32'd1);
        pop_one();
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
